// File: rtl/instr_pkg.sv
// instr_pkg: shared instruction field widths, bit positions and packing helper for encoder/decoder.
package instr_pkg;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 4;
    localparam int INSTR_W = 16;
    localparam int OPC_LSB = 12;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 4;
    localparam int RD_LSB  = 0;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] regdst;
    } instr_t;

    function automatic logic [INSTR_W-1:0] pack_instr(input instr_t f);
        return (INSTR_W'(f.opcode) << OPC_LSB) | (INSTR_W'(f.rs1) << RS1_LSB) |
               (INSTR_W'(f.rs2) << RS2_LSB) | (INSTR_W'(f.regdst) << RD_LSB);
    endfunction
endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: synchronous DEPTH x W FIFO with occupancy; clr flushes and outranks push/pop.
module instr_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign empty = wptr == rptr;
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into 16-bit words, buffers them and emits them with sequential addresses.
// Optional INSTR_ENC_CHECKSUM_EN adds a running XOR of emitted words on the checksum port.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPC_W-1:0]         in_opcode,
    input  logic [REG_W-1:0]         in_rs1,
    input  logic [REG_W-1:0]         in_rs2,
    input  logic [REG_W-1:0]         in_imm,
    input  logic                     in_use_imm,
    input  logic [REG_W-1:0]         in_regdst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [INSTR_W-1:0]       checksum
);
    instr_t             fields;
    logic [INSTR_W-1:0] head;
    logic               full, empty, pop;

    assign fields    = '{opcode: in_opcode, rs1: in_rs1, rs2: in_use_imm ? in_imm : in_rs2, regdst: in_regdst};
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !clr;
    // Stale storage is hidden so an empty encoder always presents a zero word.
    assign out_instr = empty ? '0 : head;

    instr_enc_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (in_valid),
        .pop   (out_ready),
        .din   (pack_instr(fields)),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) out_addr <= ADDR_W'(BASE_ADDR);
        else if (pop) out_addr <= out_addr + 1'b1;
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || clr) checksum <= '0;
        else if (pop) checksum <= checksum ^ head;
    end
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder (DEPTH=4, ADDR_W=4, BASE_ADDR=14).
module tb_instr_encoder;
    logic        clk = 0, rst = 1, clr = 0;
    logic        in_valid = 0, in_ready, in_use_imm = 0, out_valid, out_ready = 0;
    logic [3:0]  in_opcode = 0, in_rs1 = 0, in_rs2 = 0, in_imm = 0, in_regdst = 0;
    logic [15:0] out_instr, checksum;
    logic [3:0]  out_addr;
    logic [2:0]  count;
    int          n_cmp = 0, n_bad = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(14)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_regdst(in_regdst), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fields(input logic [3:0] op, r1, r2, im, input logic ui, input logic [3:0] rd);
        in_opcode = op; in_rs1 = r1; in_rs2 = r2; in_imm = im; in_use_imm = ui; in_regdst = rd;
    endtask

    function automatic logic [15:0] cs(input logic [15:0] v);
`ifdef INSTR_ENC_CHECKSUM_EN
        return v;
`else
        return 16'h0 & v;
`endif
    endfunction

    initial begin
        step(); step();
        rst = 0;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, 14);
        chk("rst_count", count, 0);
        chk("rst_checksum", checksum, 0);

        // three words with the consumer stalled
        in_valid = 1;
        fields(3, 1, 2, 4'hA, 0, 5);
        step();
        chk("pack_valid", out_valid, 1);
        chk("pack_basic", out_instr, 16'h3125);
        chk("pack_addr", out_addr, 14);
        fields(3, 1, 2, 4'hA, 1, 5);
        step();
        fields(3, 1, 2, 4'hA, 0, 5);
        step();
        in_valid = 0;
        chk("three_count", count, 3);

        // drain one at a time: addresses wrap 14,15,0
        out_ready = 1;
        step();
        chk("imm_sel", out_instr, 16'h31A5);
        chk("addr_15", out_addr, 15);
        chk("cs_1", checksum, cs(16'h3125));
        step();
        chk("imm_ignored", out_instr, 16'h3125);
        chk("addr_wrap", out_addr, 0);
        chk("cs_2", checksum, cs(16'h0080));
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_count", count, 0);
        chk("drain_addr", out_addr, 1);
        chk("drain_instr", out_instr, 0);
        out_ready = 0;

        clr = 1;
        step();
        clr = 0;
        chk("clr_addr", out_addr, 14);
        chk("clr_cs", checksum, 0);

        // backpressure: 5 tuples offered, 4 accepted
        in_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            fields(4'(i), 4'(i), 0, 0, 0, 4'hF);
            chk($sformatf("full_rdy_%0d", i), in_ready, i <= 4);
            step();
        end
        in_valid = 0;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_head", out_instr, 16'h110F);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("pop_in_ready", in_ready, 1);
        chk("pop_count", count, 3);
        chk("pop_head", out_instr, 16'h220F);

        // simultaneous push and pop keeps occupancy
        in_valid = 1; out_ready = 1;
        fields(6, 6, 0, 0, 0, 4'hF);
        step();
        in_valid = 0; out_ready = 0;
        chk("pp_count", count, 3);
        chk("pp_head", out_instr, 16'h330F);
        chk("pp_addr", out_addr, 0);
        chk("pp_cs", checksum, cs(16'h3300));

        // clr outranks a simultaneous push and pop
        clr = 1; in_valid = 1; out_ready = 1;
        fields(7, 7, 7, 0, 0, 7);
        step();
        clr = 0; in_valid = 0; out_ready = 0;
        chk("clr_count", count, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_addr2", out_addr, 14);
        chk("clr_cs2", checksum, 0);
        chk("clr_in_ready", in_ready, 1);
        step();
        chk("clr_lost", count, 0);

        // rst mid-stream
        in_valid = 1;
        fields(9, 8, 7, 0, 0, 6);
        step();
        chk("rst_pre", out_instr, 16'h9876);
        rst = 1;
        step();
        rst = 0; in_valid = 0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Field-to-word instruction encoder: the write-side counterpart of the pipeline's instruction decoder. Accepts decoded instruction fields over a valid/ready handshake and packs them into 16-bit words. Packing uses the decoder's layout: opcode [15:12], Rs1 [11:8], Rs2/imm [7:4], Regdst [3:0]. Packed words are buffered in a small FIFO and emitted with a sequential instruction-memory address, so a loader or test sequencer can fill program memory for the decoder to consume.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 8, width of emitted instruction address
- BASE_ADDR, 0, first address emitted after reset/clear

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous flush: empties FIFO, address back to BASE_ADDR, checksum to 0
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept
- in_opcode  in  4  → [15:12]
- in_rs1  in  4  → [11:8]
- in_rs2  in  4  → [7:4] when in_use_imm=0
- in_imm  in  4  → [7:4] when in_use_imm=1
- in_use_imm  in  1  selects imm over Rs2
- in_regdst  in  4  → [3:0]
- out_valid  out  1  packed word available
- out_ready  in  1  consumer accepts
- out_instr  out  16  packed instruction
- out_addr  out  ADDR_W  address of out_instr
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- checksum  out  16  running XOR of emitted words (see Configuration)

## Operation
- Packing is combinational on input fields; the packed word is written into the FIFO on in_valid && in_ready.
- in_ready = !full. There is no pass-through when full, even if a pop occurs the same cycle.
- out_valid = !empty. out_instr shows the FIFO head; out_addr shows the address counter.
- Pop on out_valid && out_ready.
- On each pop, the address increments and wraps modulo 2^ADDR_W (2^ADDR_W−1 → 0).
- Simultaneous push and pop (not full, not empty): count unchanged, both take effect.
- Priority: rst > clr > handshakes. A push or pop presented in a clr cycle is discarded, and nothing is counted.
- No FSM beyond FIFO pointers; ordering is strictly FIFO.

## Timing
- Reset/clr values: in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, checksum=0.
- Latency: a tuple accepted in cycle N is visible on out_valid/out_instr in cycle N+1.
- Throughput: one word per cycle sustained when out_ready is held high.
- in_ready, out_valid and count are derived only from registered state; there is no combinational path from out_ready to in_ready.
- After a pop from full, in_ready is 1 in the next cycle.
- rst or clr mid-stream: takes effect at the next edge; out_valid is low in the following cycle.

## Configuration
- INSTR_ENC_CHECKSUM_EN defined: checksum register XORs out_instr on every pop, and clears on rst/clr.
- Undefined: no checksum register; the checksum port is driven constant 0. The port stays present so the interface is stable.

## Structure
- Shared package instr_pkg:
  - field widths OPC_W=4, REG_W=4, INSTR_W=16
  - field LSB constants 12/8/4/0
  - packed struct typedef for instruction fields
  - the decoder may reuse the package
- One sub-module: instr_enc_fifo, a generic synchronous FIFO of DEPTH×INSTR_W with count. Packing and the address/checksum logic stay in the top.

## Test plan
- Basic pack: opcode=3, rs1=1, rs2=2, regdst=5, use_imm=0 → next cycle out_instr=16'h3125, out_addr=0.
- Imm select: same tuple with imm=4'hA, use_imm=1 → 16'h31A5. With use_imm=0 and imm=4'hA → 16'h3125.
- Full/backpressure: out_ready=0, drive 5 tuples (DEPTH=4) → 4 accepted, count=4, in_ready=0 on 5th. Then one pop → in_ready=1 next cycle.
- Wrap: ADDR_W=4, BASE_ADDR=14, emit 3 words → addresses 14, 15, 0.
- clr mid-stream: 3 words buffered, clr with simultaneous in_valid and out_ready → next cycle count=0, out_valid=0, out_addr=BASE_ADDR, and the pushed word is lost.
- Checksum (macro on): emit 16'h3125 then 16'h31A5 → checksum=16'h0080. With the macro off, checksum stays 0.
